vminmax_red_ctrl: RTL and testbench

- Sequencer for vector min/max reductions: vredminu, vredmin, vredmaxu, vredmax.
- Accepts a stream of 64-bit vector beats and keeps a lane-wise running min/max accumulator.
- After the last beat, folds the accumulator lanes down to a single element over several cycles, then combines it with the scalar seed (vs1[0]).
- Sits between the vALU issue logic and the writeback path; returns one scalar result per reduction.

---
 rtl/vminmax_pkg.sv | 54 +++++
 rtl/vminmax_red_ctrl_lane_op.sv | 48 ++++
 rtl/vminmax_red_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_vminmax_red_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vminmax_pkg.sv
// Shared definitions for the vector min/max reduction sequencer.
//   - SEW codes (element width) and op-bit positions
//   - FSM state enum
//   - identity(): 64-bit replicated identity pattern for an (op, sew) pair
//   - sew_mask(): low-bit mask covering one element at a given SEW
package vminmax_pkg;

  localparam logic [1:0] SEW8  = 2'd0;
  localparam logic [1:0] SEW16 = 2'd1;
  localparam logic [1:0] SEW32 = 2'd2;
  localparam logic [1:0] SEW64 = 2'd3;

  // Bit positions inside the 2-bit op code.
  localparam int OP_MAX    = 0;
  localparam int OP_SIGNED = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Identity element replicated across every element slot of a 64-bit beat.
  function automatic logic [63:0] identity(input logic [1:0] op, input logic [1:0] sew);
    logic [63:0] msb;
    logic [63:0] id;
    case (sew)
      SEW8:    msb = {8{8'h80}};
      SEW16:   msb = {4{16'h8000}};
      SEW32:   msb = {2{32'h8000_0000}};
      default: msb = 64'h8000_0000_0000_0000;
    endcase
    case ({op[OP_SIGNED], op[OP_MAX]})
      2'b00:   id = '1;    // minu
      2'b01:   id = '0;    // maxu
      2'b10:   id = ~msb;  // min: 0x7F..
      default: id = msb;   // max: 0x80..
    endcase
    return id;
  endfunction

  function automatic logic [63:0] sew_mask(input logic [1:0] sew);
    logic [63:0] m;
    case (sew)
      SEW8:    m = 64'h0000_0000_0000_00FF;
      SEW16:   m = 64'h0000_0000_0000_FFFF;
      SEW32:   m = 64'h0000_0000_FFFF_FFFF;
      default: m = '1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vminmax_red_ctrl_lane_op.sv
// Combinational lane-wise min/max at runtime element width.
//   i_a, i_b : 64-bit operands, packed little-endian elements
//   i_sew    : element width code (0=8b .. 3=64b)
//   i_op     : bit0 max/min, bit1 signed/unsigned
//   o_y      : per-element op(a,b); ties return a
// All four widths are computed in parallel and the result is picked by i_sew.
module vminmax_lane_op
  import vminmax_pkg::*;
(
  input  logic [63:0] i_a,
  input  logic [63:0] i_b,
  input  logic [1:0]  i_sew,
  input  logic [1:0]  i_op,
  output logic [63:0] o_y
);

  logic [255:0] w_res;

  for (genvar g = 0; g < 4; g++) begin : g_sew
    localparam int EW = 8 << g;
    for (genvar i = 0; i < 64 / EW; i++) begin : g_el
      logic [EW-1:0] w_ea;
      logic [EW-1:0] w_eb;
      logic          w_xa;
      logic          w_xb;
      logic          w_pick_b;
      assign w_ea = i_a[i*EW +: EW];
      assign w_eb = i_b[i*EW +: EW];
      // One extra top bit makes a single signed compare serve both signednesses.
      assign w_xa = i_op[OP_SIGNED] & w_ea[EW-1];
      assign w_xb = i_op[OP_SIGNED] & w_eb[EW-1];
      assign w_pick_b = i_op[OP_MAX] ? ($signed({w_xb, w_eb}) > $signed({w_xa, w_ea}))
                                     : ($signed({w_xb, w_eb}) < $signed({w_xa, w_ea}));
      assign w_res[g*64 + i*EW +: EW] = w_pick_b ? w_eb : w_ea;
    end
  end

  always_comb begin
    o_y = w_res[63:0];
    case (i_sew)
      SEW8:    o_y = w_res[63:0];
      SEW16:   o_y = w_res[127:64];
      SEW32:   o_y = w_res[191:128];
      default: o_y = w_res[255:192];
    endcase
  end

endmodule

// File: rtl/vminmax_red_ctrl.sv
// Vector min/max reduction sequencer (vredminu/vredmin/vredmaxu/vredmax).
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid/in_ready    : beat handshake; in_data, in_first, in_last
//   in_sew/in_op/in_scalar : sampled on the first beat
//   in_mask              : per-byte-lane element mask (only with VMINMAX_RED_MASK_EN)
//   out_valid/out_ready  : result handshake; out_data zero-extended from SEW
//   busy                 : state != IDLE
//   dbg_state            : current FSM state
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; the producer holds its payload until then, and out_data/out_valid stay
// stable while out_ready is low.
// Optional feature macro: VMINMAX_RED_MASK_EN (masked elements become identity).
module vminmax_red_ctrl
  import vminmax_pkg::*;
#(
  parameter int REQ_DATA_WIDTH  = 64,
  parameter int RESP_DATA_WIDTH = 64,
  parameter int SEW_WIDTH       = 2,
  parameter int MASK_WIDTH      = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [REQ_DATA_WIDTH-1:0]  in_data,
  input  logic                       in_first,
  input  logic                       in_last,
  input  logic [SEW_WIDTH-1:0]       in_sew,
  input  logic [1:0]                 in_op,
  input  logic [REQ_DATA_WIDTH-1:0]  in_scalar,
`ifdef VMINMAX_RED_MASK_EN
  input  logic [MASK_WIDTH-1:0]      in_mask,
`endif
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [RESP_DATA_WIDTH-1:0] out_data,
  output logic                       busy,
  output state_t                     dbg_state
);

  state_t                      r_state;
  logic [SEW_WIDTH-1:0]        r_sew;
  logic [1:0]                  r_op;
  logic [REQ_DATA_WIDTH-1:0]   r_scalar;
  logic [REQ_DATA_WIDTH-1:0]   r_acc;
  logic [REQ_DATA_WIDTH-1:0]   r_res;
  logic [2:0]                  r_step;
  logic                        r_in_ready;
  logic                        r_out_valid;
  logic [RESP_DATA_WIDTH-1:0]  r_out_data;
  logic                        r_busy;

  logic                        w_beat_fire;
  logic [REQ_DATA_WIDTH-1:0]   w_beat;
  logic [2:0]                  w_fold_n;
  logic [63:0]                 w_op_b;
  logic [63:0]                 w_op_y;

  assign w_beat_fire = in_valid && r_in_ready;
  assign w_fold_n    = 3'd3 - {1'b0, r_sew};

`ifdef VMINMAX_RED_MASK_EN
  // On a first beat the new sew/op apply, otherwise the latched ones.
  logic [1:0]  w_beat_sew;
  logic [1:0]  w_beat_op;
  logic [63:0] w_ident;
  logic [2:0]  w_bsel;
  assign w_beat_sew = in_first ? in_sew : r_sew;
  assign w_beat_op  = in_first ? in_op  : r_op;
  assign w_ident    = identity(w_beat_op, w_beat_sew);

  // Each byte takes the mask bit of its element's lowest byte lane.
  always_comb begin
    w_beat = in_data;
    w_bsel = 3'd0;
    for (int j = 0; j < 8; j++) begin
      case (w_beat_sew)
        SEW8:    w_bsel = 3'(j);
        SEW16:   w_bsel = 3'(j) & 3'b110;
        SEW32:   w_bsel = 3'(j) & 3'b100;
        default: w_bsel = 3'd0;
      endcase
      w_beat[j*8 +: 8] = in_mask[w_bsel] ? in_data[j*8 +: 8] : w_ident[j*8 +: 8];
    end
  end
`else
  assign w_beat = in_data;
`endif

  // Operand b of the shared lane op: the beat while accumulating, the upper
  // half of the active width while folding, then the scalar seed.
  always_comb begin
    w_op_b = w_beat;
    if (r_state == FOLD) begin
      if (r_step < w_fold_n) begin
        case (r_step)
          3'd0:    w_op_b = {32'b0, r_acc[63:32]};
          3'd1:    w_op_b = {16'b0, r_acc[63:16]};
          default: w_op_b = {8'b0,  r_acc[63:8]};
        endcase
      end else begin
        w_op_b = r_scalar;
      end
    end
  end

  vminmax_lane_op u_lane_op (
    .i_a   (r_acc),
    .i_b   (w_op_b),
    .i_sew (r_sew),
    .i_op  (r_op),
    .o_y   (w_op_y)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_sew       <= '0;
      r_op        <= '0;
      r_scalar    <= '0;
      r_acc       <= '0;
      r_res       <= '0;
      r_step      <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_beat_fire) begin
            if (in_first) begin
              r_sew    <= in_sew;
              r_op     <= in_op;
              r_scalar <= in_scalar;
              r_acc    <= w_beat;
            end else if (r_state == ACCUM) begin
              r_acc <= w_op_y;
            end
            // A non-first beat in IDLE is dropped without any state change.
            if (in_first || (r_state == ACCUM)) begin
              r_step <= '0;
              r_busy <= 1'b1;
              if (in_last) begin
                r_state    <= FOLD;
                r_in_ready <= 1'b0;
              end else begin
                r_state <= ACCUM;
              end
            end
          end
        end
        FOLD: begin
          r_step <= r_step + 3'd1;
          if (r_step < w_fold_n) begin
            r_acc <= w_op_y;
          end else if (r_step == w_fold_n) begin
            r_res <= w_op_y & sew_mask(r_sew);
          end else begin
            // Output register stage: result becomes visible here.
            r_state     <= DONE;
            r_out_valid <= 1'b1;
            r_out_data  <= r_res;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_vminmax_red_ctrl.sv
module tb_vminmax_red_ctrl;
  import vminmax_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_first;
  logic        in_last;
  logic [1:0]  in_sew;
  logic [1:0]  in_op;
  logic [63:0] in_scalar;
`ifdef VMINMAX_RED_MASK_EN
  logic [7:0]  in_mask;
`endif
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;
  state_t      dbg_state;

  vminmax_red_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_sew    (in_sew),
    .in_op     (in_op),
    .in_scalar (in_scalar),
`ifdef VMINMAX_RED_MASK_EN
    .in_mask   (in_mask),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got %h expected none", out_data);
      end else begin
        check("result", out_data, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] elem(input logic [63:0] v, input logic [1:0] sew, input int i);
    int w;
    logic [63:0] m;
    w = 8 << sew;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >> (i * w)) & m;
  endfunction

  function automatic logic [63:0] ref_op(input logic [63:0] a, input logic [63:0] b,
                                         input logic [1:0] sew, input logic [1:0] op);
    int w;
    logic signed [65:0] xa;
    logic signed [65:0] xb;
    logic pick;
    w  = 8 << sew;
    xa = $signed({2'b00, a});
    xb = $signed({2'b00, b});
    if (op[1] && a[w-1]) xa = xa - (66'sd1 <<< w);
    if (op[1] && b[w-1]) xb = xb - (66'sd1 <<< w);
    pick = op[0] ? (xb > xa) : (xb < xa);
    return pick ? b : a;
  endfunction

  typedef struct {
    logic [1:0]       sew;
    logic [1:0]       op;
    logic [63:0]      scalar;
    logic [7:0]       mask;
    int               nb;
    logic [3:0][63:0] beats;
    logic [63:0]      exp;
  } vec_t;

  function automatic logic [63:0] ref_reduce(input vec_t v);
    logic [63:0] r;
    logic        act;
    r = elem(v.scalar, v.sew, 0);
    for (int k = 0; k < v.nb; k++) begin
      for (int i = 0; i < (8 >> v.sew); i++) begin
`ifdef VMINMAX_RED_MASK_EN
        act = v.mask[i * (1 << v.sew)];
`else
        act = 1'b1;
`endif
        if (act) r = ref_op(r, elem(v.beats[k], v.sew, i), v.sew, v.op);
      end
    end
    return r;
  endfunction

  function automatic vec_t mk(input logic [1:0] sew, input logic [1:0] op, input logic [63:0] scalar,
                              input int nb, input logic [63:0] b0, input logic [63:0] b1,
                              input logic [63:0] exp);
    vec_t v;
    v.sew = sew; v.op = op; v.scalar = scalar; v.mask = 8'hFF; v.nb = nb;
    v.beats[0] = b0; v.beats[1] = b1; v.beats[2] = '0; v.beats[3] = '0;
    v.exp = exp;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic first, input logic last, input logic [63:0] data,
                           input logic [1:0] sew, input logic [1:0] op,
                           input logic [63:0] scalar, input logic [7:0] mask);
    int t;
    in_valid  = 1'b1;
    in_first  = first;
    in_last   = last;
    in_data   = data;
    in_sew    = sew;
    in_op     = op;
    in_scalar = scalar;
`ifdef VMINMAX_RED_MASK_EN
    in_mask   = mask;
`else
    if (mask == 8'h00) t = 0;
`endif
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("beat_accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends all beats, then measures edges from last-beat acceptance to out_valid
  // and checks in_ready stays low while the result is being formed.
  task automatic run_red(input vec_t v, input bit push, output int lat, output bit rdy_seen);
    for (int k = 0; k < v.nb; k++) begin
      if (push && k == v.nb - 1) exp_q.push_back(v.exp);
      send_beat(k == 0, k == v.nb - 1, v.beats[k], v.sew, v.op, v.scalar, v.mask);
    end
    lat = 0;
    rdy_seen = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < 20) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (lat >= 20) check("out_valid_timeout", 64'(out_valid), 64'd1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  vec_t        tbl[8];
  vec_t        v;
  int          lat;
  bit          rdy_seen;
  logic [63:0] held;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    in_data = '0; in_sew = '0; in_op = '0; in_scalar = '0; out_ready = 1'b1;
`ifdef VMINMAX_RED_MASK_EN
    in_mask = 8'hFF;
`endif

    tbl[0] = mk(SEW8,  2'b01, 64'h0, 1, 64'h0102030405060708, 64'h0, 64'h08);
    tbl[1] = mk(SEW16, 2'b10, 64'h0, 2, 64'h0005_FFFE_0003_0007, 64'h7FFF_8000_0001_0002, 64'h8000);
    tbl[2] = mk(SEW64, 2'b11, 64'h8000_0000_0000_0000, 2, 64'hFFFF_FFFF_FFFF_FFFF,
                64'h0000_0000_0000_0005, 64'h5);
    tbl[3] = mk(SEW8,  2'b10, 64'h0, 1, 64'h7F80017F00FF0203, 64'h0, 64'h80);
    tbl[4] = mk(SEW32, 2'b00, 64'hFFFF_FFFF, 2, 64'h00000009_FFFFFFFF, 64'h00000100_00000007, 64'h7);
    tbl[5] = mk(SEW16, 2'b01, 64'hDEAD_0000_0000_0001, 1, 64'h1234_FFFF_0000_8000, 64'h0, 64'hFFFF);
    tbl[6] = mk(SEW8,  2'b00, 64'h55, 1, 64'h5555_5555_5555_5555, 64'h0, 64'h55);
    tbl[7] = mk(SEW32, 2'b11, 64'h8000_0000, 1, 64'h00000001_FFFFFFFF, 64'h0, 64'h1);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data",  out_data,       64'd0);
    check("reset_busy",      64'(busy),      64'd0);
    check("reset_state",     64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;

    // Table vectors with latency and in_ready-during-fold checks.
    for (int i = 0; i < 8; i++) begin
      run_red(tbl[i], 1'b1, lat, rdy_seen);
      check("latency", 64'(lat), 64'(3 - int'(tbl[i].sew) + 2));
      check("in_ready_in_fold", 64'(rdy_seen), 64'd0);
    end

    // Backpressure: SEW64 minu, result held while out_ready is low.
    out_ready = 1'b0;
    v = mk(SEW64, 2'b00, 64'h10, 1, 64'h20, 64'h0, 64'h10);
    run_red(v, 1'b1, lat, rdy_seen);
    check("latency_sew64", 64'(lat), 64'd2);
    held = out_data;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_data = 64'hAAAA;
      @(negedge clk);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      check("bp_out_data",  out_data,       64'h10);
      check("bp_stable",    out_data,       held);
      check("bp_in_ready",  64'(in_ready),  64'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_release_idle", 64'(busy), 64'd0);
    check("bp_release_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Reset during FOLD, then a fresh reduction.
    send_beat(1'b1, 1'b1, 64'h00000001_FFFFFFFF, SEW32, 2'b11, 64'h8000_0000, 8'hFF);
    @(negedge clk);
    check("rst_in_fold_state", 64'(dbg_state), 64'(FOLD));
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    run_red(tbl[7], 1'b1, lat, rdy_seen);
    check("latency_after_rst", 64'(lat), 64'd3);

    // First beat arriving mid-accumulation abandons the old reduction.
    send_beat(1'b1, 1'b0, 64'h0101_0101_0101_0101, SEW8, 2'b00, 64'hFF, 8'hFF);
    send_beat(1'b0, 1'b0, 64'h0202_0202_0202_0202, SEW8, 2'b00, 64'hFF, 8'hFF);
    @(negedge clk);
    check("accum_state", 64'(dbg_state), 64'(ACCUM));
    @(posedge clk); #1;
    v = mk(SEW8, 2'b00, 64'hFF, 1, 64'h1111_1111_1111_1111, 64'h0, 64'h11);
    run_red(v, 1'b1, lat, rdy_seen);

    // Beat without in_first in IDLE is dropped.
    send_beat(1'b0, 1'b1, 64'h1234, SEW8, 2'b00, 64'h0, 8'hFF);
    @(negedge clk);
    check("idle_drop_state", 64'(dbg_state), 64'(IDLE));
    @(posedge clk); #1;

`ifdef VMINMAX_RED_MASK_EN
    v = mk(SEW8, 2'b01, 64'h03, 1, 64'hFF00000000000009, 64'h0, 64'h09);
    v.mask = 8'h7F;
    run_red(v, 1'b1, lat, rdy_seen);
    v.mask = 8'h00;
    v.exp  = 64'h03;
    run_red(v, 1'b1, lat, rdy_seen);
`endif

    // Random reductions against the element-wise reference model.
    for (int r = 0; r < 10; r++) begin
      v.sew    = 2'($urandom_range(0, 3));
      v.op     = 2'($urandom_range(0, 3));
      v.scalar = {$urandom, $urandom};
      v.mask   = 8'($urandom_range(0, 255));
      v.nb     = $urandom_range(1, 4);
      for (int k = 0; k < 4; k++) v.beats[k] = {$urandom, $urandom};
      v.exp    = ref_reduce(v);
      run_red(v, 1'b1, lat, rdy_seen);
      check("rand_latency", 64'(lat), 64'(3 - int'(v.sew) + 2));
    end

    repeat (5) @(posedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
